// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider producing quotient in Lo and remainder in Hi.
// Optional HILO_DIV_ZERO_FASTPATH_EN: a zero divisor skips the iterative phase.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_signed, r_neg_a, r_neg_b;
    logic [WIDTH-1:0] r_a, r_quo, r_rem, r_dvs;
    logic [WIDTH-1:0] r_lo, r_hi;
    logic             r_done, r_dbz;
    logic [WIDTH:0]   w_shift, w_diff;
    logic [WIDTH-1:0] w_lo_fin, w_hi_fin;
    logic             w_accept, w_b_zero, w_dvs_zero;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_b_zero   = (i_b == '0);
    assign w_dvs_zero = (r_dvs == '0);

    // Trial subtraction of the divisor from the shifted partial remainder
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_lo_fin = (r_signed && (r_neg_a != r_neg_b)) ? -r_quo : r_quo;
        w_hi_fin = (r_signed && r_neg_a) ? -r_rem : r_rem;
        if (w_dvs_zero) begin
            w_lo_fin = '1;
            w_hi_fin = r_a;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
`ifdef HILO_DIV_ZERO_FASTPATH_EN
                    w_next = w_b_zero ? S_FIX : S_RUN;
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Control and architectural result registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt <= CW'(WIDTH);
                r_dbz <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
            end else if (r_state == S_FIX) begin
                r_cnt  <= '0;
                r_lo   <= w_lo_fin;
                r_hi   <= w_hi_fin;
                r_done <= 1'b1;
                r_dbz  <= w_dvs_zero;
            end
        end
    end

    // Operand latch and iterative datapath; contents are don't-care outside an operation
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_signed <= i_signed;
            r_neg_a  <= i_signed & i_a[WIDTH-1];
            r_neg_b  <= i_signed & i_b[WIDTH-1];
            r_a      <= i_a;
            r_quo    <= magnitude(i_a, i_signed);
            r_dvs    <= magnitude(i_b, i_signed);
            r_rem    <= '0;
        end else if (r_state == S_RUN) begin
            r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
            r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end
    end

    assign o_lo          = r_lo;
    assign o_hi          = r_hi;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;

    logic w_unused;
    assign w_unused = w_b_zero;
endmodule

// File: tb/tb_hilo_divider.sv
// Directed self-checking bench for hilo_divider (WIDTH=32), immediate assertions.
module tb_hilo_divider;
    localparam int W = 32;
`ifdef HILO_DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic         clk = 1'b0;
    logic         rst, start, sgn;
    logic [W-1:0] a, b, lo, hi;
    logic         busy, done, dbz;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    hilo_divider #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn),
        .i_a(a), .i_b(b),
        .o_lo(lo), .o_hi(hi), .o_busy(busy), .o_done(done), .o_div_by_zero(dbz)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One division; inj >= 0 pulses a spurious Start into the edge following cycle inj.
    task automatic run_div(input string tag, input logic s, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input logic [W-1:0] elo,
                           input logic [W-1:0] ehi, input logic edbz, input int elat,
                           input int inj);
        int n;
        logic got, busy_bad, hold_bad;
        logic [W-1:0] plo, phi;
        @(negedge clk);
        plo = lo; phi = hi;
        start = 1'b1; sgn = s; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; sgn = ~s;
        chk({tag, " busy@E0"}, W'(busy), W'(1));
        chk({tag, " done@E0"}, W'(done), W'(0));
        chk({tag, " dbz@E0"}, W'(dbz), W'(0));
        n = 0; got = 1'b0; busy_bad = 1'b0; hold_bad = 1'b0;
        while (!got && n < 40) begin
            if (n == inj) begin start = 1'b1; a = 32'd1; b = 32'd1; sgn = 1'b0; end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) got = 1'b1;
            else begin
                if (!busy) busy_bad = 1'b1;
                if (lo !== plo || hi !== phi) hold_bad = 1'b1;
            end
        end
        chk({tag, " latency"}, W'(n), W'(elat));
        chk({tag, " lo"}, lo, elo);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " dbz"}, W'(dbz), W'(edbz));
        chk({tag, " busy@done"}, W'(busy), W'(0));
        chk({tag, " busy_during_run"}, W'(busy_bad), W'(0));
        chk({tag, " lohi_hold"}, W'(hold_bad), W'(0));
    endtask

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset lo", lo, '0);
        chk("reset hi", hi, '0);
        chk("reset busy", W'(busy), W'(0));
        chk("reset done", W'(done), W'(0));
        chk("reset dbz", W'(dbz), W'(0));
        @(negedge clk) rst = 1'b0;

        run_div("u100_7",  1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33, -1);
        run_div("s-7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, -1);
        run_div("u-7_2",   1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0, 33, -1);
        run_div("s_ovf",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33, -1);
        run_div("u5_0",    1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, ZLAT, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("dbz held idle", W'(dbz), W'(1));
        run_div("s-5_0",   1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, ZLAT, -1);
        run_div("s7_-2",   1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33, -1);
        run_div("s-7_-2",  1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 33, -1);
        run_div("u_big",   1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0, 33, -1);
        run_div("u3_10",   1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 33, -1);
        // Spurious Start sampled at E10 while running
        run_div("ign_start", 1'b0, 32'd1000,   32'd9,        32'd111,      32'd1,        1'b0, 33, 9);

        // Reset asserted just after E10 abandons the operation
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun rst lo", lo, '0);
        chk("midrun rst hi", hi, '0);
        chk("midrun rst busy", W'(busy), W'(0));
        chk("midrun rst done", W'(done), W'(0));
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("no done after rst", W'(seen), W'(0));
        chk("busy after rst", W'(busy), W'(0));

        run_div("post_rst", 1'b0, 32'd100,     32'd7,        32'd14,       32'd2,        1'b0, 33, -1);
        // Start issued in the Done cycle of the previous division
        run_div("b2b",      1'b1, 32'hFFFFFF9C, 32'd7,       32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
